spdif_subframe_encoder: RTL and testbench

// - Parametrised IEC 60958 (S/PDIF) transmitter. Takes stereo sample pairs over a valid/ready

---
 rtl/spdif_subframe_encoder.sv | 221 ++++++++++++++++++++++
 tb/tb_spdif_subframe_encoder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spdif_subframe_encoder.sv
// spdif_subframe_encoder
//   IEC 60958 (S/PDIF) transmitter. It accepts stereo sample pairs over a
//   valid/ready handshake and emits a biphase-mark cell stream. The stream has
//   B/M/W preambles, V/U/C/P bits and 192-frame channel-status blocks.
//   clk is the cell clock (2x bit rate): 64 cells per subframe, 128 per frame.
//
// Parameters
//   SAMPLE_W    audio bits per channel (16..24), MSB-aligned in the 24-bit field
//   CS_DEFAULT  channel-status block used until the first block latch
//
// Ports
//   clk, rst_n        cell clock, asynchronous active-low reset
//   enable            run request; dropping it finishes the current frame
//   s_valid/s_ready   sample-pair handshake (s_ready = holding register empty)
//   s_left/s_right    channel A / channel B samples, two's complement
//   cs_data           channel-status block, bit n = C bit of frame n
//   u_data            user-data block (only with USER_DATA_EN)
//   dout              biphase-mark serial output (registered)
//   block_start       high while dout carries cell 0 of a B preamble
//   underrun          1-cycle pulse: a frame started with no sample held
//
// Build option
//   USER_DATA_EN  adds u_data[191:0], latched with cs_data; U = u_reg[frame].
//                 Without it U is always 0.

module spdif_subframe_encoder #(
    parameter int unsigned  SAMPLE_W   = 20,
    parameter logic [191:0] CS_DEFAULT = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_left,
    input  logic [SAMPLE_W-1:0] s_right,
    input  logic [191:0]        cs_data,
`ifdef USER_DATA_EN
    input  logic [191:0]        u_data,
`endif
    output logic                dout,
    output logic                block_start,
    output logic                underrun
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STOPPING
    } state_t;

    // Preamble cell patterns for a previous level of 0, first cell in the MSB.
    localparam logic [7:0] PRE_B = 8'b11101000;
    localparam logic [7:0] PRE_M = 8'b11100010;
    localparam logic [7:0] PRE_W = 8'b11100100;

    state_t              state;
    state_t              state_nxt;
    logic [6:0]          phase;
    logic [7:0]          frame;
    logic                rdy_ok;
    logic                hold_full;
    logic [SAMPLE_W-1:0] hold_l;
    logic [SAMPLE_W-1:0] hold_r;
    logic [SAMPLE_W-1:0] samp_l;
    logic [SAMPLE_W-1:0] samp_r;
    logic                v_bit;
    logic                par_acc;
    logic                pre_inv;
    logic [191:0]        cs_reg;
    logic                u_bit;

    logic                active;
    logic                last_cell;
    logic                load;
    logic                frame_start;
    logic [4:0]          slot;
    logic [2:0]          pre_idx;
    logic                in_pre;
    logic [23:0]         field;
    logic [7:0]          pre_pat;
    logic                data_bit;
    logic                cell_nxt;

`ifdef USER_DATA_EN
    logic [191:0]        u_reg;
    assign u_bit = u_reg[frame];
`else
    assign u_bit = 1'b0;
`endif

    // s_ready stays low through reset and rises one cycle after release.
    assign s_ready = rdy_ok & ~hold_full;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (enable) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // enable dropping at the last cell finishes the frame right away
                if (!enable) state_nxt = (phase == 7'd127) ? ST_IDLE : ST_STOPPING;
            end
            ST_STOPPING: begin
                if (phase == 7'd127) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output / cell logic
    always_comb begin
        active      = (state != ST_IDLE);
        last_cell   = (phase == 7'd127);
        load        = enable && ((state == ST_IDLE) || ((state == ST_RUN) && last_cell));
        frame_start = active && (phase == 7'd0) && (frame == 8'd0);
        slot        = phase[5:1];
        pre_idx     = phase[2:0];
        in_pre      = (slot < 5'd4);
        field       = phase[6] ? (24'(samp_r) << (24 - SAMPLE_W))
                               : (24'(samp_l) << (24 - SAMPLE_W));

        if (phase[6])           pre_pat = PRE_W;
        else if (frame == 8'd0) pre_pat = PRE_B;
        else                    pre_pat = PRE_M;

        data_bit = 1'b0;
        if ((slot >= 5'd4) && (slot <= 5'd27)) data_bit = field[slot - 5'd4];
        else if (slot == 5'd28)                data_bit = v_bit;
        else if (slot == 5'd29)                data_bit = u_bit;
        else if (slot == 5'd30)                data_bit = cs_reg[frame];
        else if (slot == 5'd31)                data_bit = par_acc;

        // Preamble polarity follows the level before cell 0, remembered for cells 1..7.
        if (in_pre)         cell_nxt = pre_pat[3'd7 - pre_idx] ^ ((pre_idx == 3'd0) ? dout : pre_inv);
        else if (!phase[0]) cell_nxt = ~dout;
        else                cell_nxt = dout ^ data_bit;
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase       <= '0;
            frame       <= '0;
            rdy_ok      <= 1'b0;
            hold_full   <= 1'b0;
            hold_l      <= '0;
            hold_r      <= '0;
            samp_l      <= '0;
            samp_r      <= '0;
            v_bit       <= 1'b0;
            par_acc     <= 1'b0;
            pre_inv     <= 1'b0;
            cs_reg      <= CS_DEFAULT;
`ifdef USER_DATA_EN
            u_reg       <= '0;
`endif
            dout        <= 1'b0;
            block_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            rdy_ok      <= 1'b1;
            block_start <= frame_start;
            underrun    <= load & ~hold_full;

            if (active) begin
                dout  <= cell_nxt;
                phase <= phase + 7'd1;
                if (last_cell) begin
                    frame <= ((state_nxt == ST_IDLE) || (frame == 8'd191)) ? 8'd0 : frame + 8'd1;
                end
                if (in_pre) begin
                    par_acc <= 1'b0;
                    if (pre_idx == 3'd0) pre_inv <= dout;
                end else if (phase[0] && (slot != 5'd31)) begin
                    par_acc <= par_acc ^ data_bit;
                end
            end

            if (frame_start) begin
                cs_reg <= cs_data;
`ifdef USER_DATA_EN
                u_reg  <= u_data;
`endif
            end

            // Load samples hold_full as it was before this edge; a pair accepted
            // on the same edge lands in the holding register for the next frame.
            if (load) begin
                if (hold_full) begin
                    samp_l    <= hold_l;
                    samp_r    <= hold_r;
                    v_bit     <= 1'b0;
                    hold_full <= 1'b0;
                end else begin
                    samp_l <= '0;
                    samp_r <= '0;
                    v_bit  <= 1'b1;
                end
            end

            if (s_valid && s_ready) begin
                hold_l    <= s_left;
                hold_r    <= s_right;
                hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spdif_subframe_encoder.sv
`timescale 1ns/1ps
module tb_spdif_subframe_encoder;

    localparam int SW = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [SW-1:0] s_left = '0;
    logic [SW-1:0] s_right = '0;
    logic [191:0]  cs_data = '0;
`ifdef USER_DATA_EN
    logic [191:0]  u_data = '0;
`endif
    logic          dout;
    logic          block_start;
    logic          underrun;

    spdif_subframe_encoder #(
        .SAMPLE_W   (SW),
        .CS_DEFAULT (192'h0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_left      (s_left),
        .s_right     (s_right),
        .cs_data     (cs_data),
`ifdef USER_DATA_EN
        .u_data      (u_data),
`endif
        .dout        (dout),
        .block_start (block_start),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   e0 = 1000000;
    int   e1 = 1000000;
    logic hist [0:32767];
    int   bs_q[$];
    int   ur_q[$];
    int   pre_err, bp_err, par_err, c_err, v_err, u_err, hold_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sample pair k offered by the feeder
    function automatic logic [SW-1:0] pl(input int k);
        if (k == 0) return 20'h00001;
        if (k == 1) return 20'h80001;
        return SW'(32'h0A5C3 + k * 32'h0F17);
    endfunction

    function automatic logic [SW-1:0] pr(input int k);
        if (k == 0) return 20'h80001;
        return ~pl(k);
    endfunction

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic int fbase(input int g);
        return e0 + 1 + 128 * g;
    endfunction

    function automatic logic dbit(input int base, input int sb, input int s);
        return hist[base + 64*sb + 2*s] ^ hist[base + 64*sb + 2*s + 1];
    endfunction

    function automatic logic [23:0] fld(input int base, input int sb);
        logic [23:0] v;
        for (int s = 0; s < 24; s++) v[s] = dbit(base, sb, s + 4);
        return v;
    endfunction

    function automatic logic [7:0] pre_cells(input int base, input int sb);
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[7-k] = hist[base + 64*sb + k];
        return v;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && s_valid && s_ready) acc_cnt <= acc_cnt + 1;
    end

    always @(negedge clk) begin
        if (cyc < 32768) hist[cyc] = dout;
        if (block_start) bs_q.push_back(cyc);
        if (underrun) ur_q.push_back(cyc);
    end

    // Feeder: always offers the next pair, except across two chosen frame loads.
    initial begin
        int t;
        forever begin
            @(negedge clk);
            t = cyc + 1 - e0;
            s_valid = !(((t >= 257) && (t <= 384)) || ((t >= 513) && (t <= 639)));
            s_left  = pl(acc_cnt);
            s_right = pr(acc_cnt);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int idx_end;
        logic c_exp, v_exp, u_exp, x;
        logic [7:0] pexp;

        cs_data = 192'h4;
`ifdef USER_DATA_EN
        u_data = 192'h20;
`endif
        repeat (3) @(negedge clk);
        check("rst_dout", dout, 1'b0);
        check("rst_block_start", block_start, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_s_ready", s_ready, 1'b0);

        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", s_ready, 1'b1);
        @(negedge clk);
        check("ready_hold_full", s_ready, 1'b0);

        enable = 1'b1;
        e0 = cyc + 1;
        while (cyc + 1 < e0 + 200) @(negedge clk);
        cs_data = 192'h8;
        while (cyc + 1 < fbase(195) + 40) @(negedge clk);
        enable = 1'b0;
        while (cyc < fbase(196) + 100) @(negedge clk);
        enable = 1'b1;
        e1 = cyc + 1;
        repeat (20) @(negedge clk);

        // Reset release and block timing
        check("first_preamble", pre_cells(fbase(0), 0), 8'hE8);
        check("block_start_count", bs_q.size(), 3);
        check("block_start_0", qget(bs_q, 0), e0 + 1);
        check("block_start_1", qget(bs_q, 1), e0 + 1 + 24576);
        check("block_start_restart", qget(bs_q, 2), e1 + 1);
        check("restart_preamble", pre_cells(e1 + 1, 0), 8'hE8 ^ {8{hist[e1]}});

        // Field contents of the first frames
        check("f0_left_field", fld(fbase(0), 0), 24'h000010);
        check("f0_left_v", dbit(fbase(0), 0, 28), 1'b0);
        check("f0_left_u", dbit(fbase(0), 0, 29), 1'b0);
        check("f0_left_c", dbit(fbase(0), 0, 30), 1'b0);
        check("f0_left_p", dbit(fbase(0), 0, 31), 1'b1);
        check("f0_right_field", fld(fbase(0), 1), 24'h800010);
        check("f0_right_p", dbit(fbase(0), 1, 31), 1'b0);
        check("f1_left_field", fld(fbase(1), 0), 24'h800010);
        check("f1_left_p", dbit(fbase(1), 0, 31), 1'b0);

        // Stalled load (frame 3) and pair offered at phase 127 (frame 5)
        check("underrun_count", ur_q.size(), 2);
        check("underrun_0", qget(ur_q, 0), e0 + 384);
        check("underrun_1", qget(ur_q, 1), e0 + 640);
        check("f3_left_field", fld(fbase(3), 0), 24'h0);
        check("f3_right_field", fld(fbase(3), 1), 24'h0);
        check("f3_left_v", dbit(fbase(3), 0, 28), 1'b1);
        check("f3_right_v", dbit(fbase(3), 1, 28), 1'b1);
        check("f3_left_p", dbit(fbase(3), 0, 31), 1'b1);
        check("f3_right_p", dbit(fbase(3), 1, 31), 1'b1);
        check("f4_left_field", fld(fbase(4), 0), 24'({pl(3), 4'h0}));
        check("f4_right_field", fld(fbase(4), 1), 24'({pr(3), 4'h0}));
        check("f5_left_field", fld(fbase(5), 0), 24'h0);
        check("f5_right_v", dbit(fbase(5), 1, 28), 1'b1);
`ifdef USER_DATA_EN
        check("f5_left_p", dbit(fbase(5), 0, 31), 1'b0);
`else
        check("f5_left_p", dbit(fbase(5), 0, 31), 1'b1);
`endif
        check("f6_left_field", fld(fbase(6), 0), 24'({pl(4), 4'h0}));
        check("f6_right_field", fld(fbase(6), 1), 24'({pr(4), 4'h0}));
        check("f6_left_v", dbit(fbase(6), 0, 28), 1'b0);
        check("f7_left_field", fld(fbase(7), 0), 24'({pl(5), 4'h0}));

        // Whole-stream scan: preambles, biphase transitions, parity, V/U/C
        pre_err = 0; bp_err = 0; par_err = 0; c_err = 0; v_err = 0; u_err = 0;
        for (int g = 0; g < 196; g++) begin
            base  = fbase(g);
            c_exp = (g < 192) ? (g == 2) : (g == 195);
            v_exp = (g == 3) || (g == 5);
`ifdef USER_DATA_EN
            u_exp = ((g % 192) == 5);
`else
            u_exp = 1'b0;
`endif
            for (int sb = 0; sb < 2; sb++) begin
                if (sb == 1)             pexp = 8'hE4;
                else if (g % 192 == 0)   pexp = 8'hE8;
                else                     pexp = 8'hE2;
                pexp = pexp ^ {8{hist[base + 64*sb - 1]}};
                if (pre_cells(base, sb) !== pexp) pre_err++;
                x = 1'b0;
                for (int s = 4; s < 32; s++) begin
                    if (hist[base + 64*sb + 2*s] === hist[base + 64*sb + 2*s - 1]) bp_err++;
                    x = x ^ dbit(base, sb, s);
                end
                if (x !== 1'b0) par_err++;
                if (dbit(base, sb, 28) !== v_exp) v_err++;
                if (dbit(base, sb, 29) !== u_exp) u_err++;
                if (dbit(base, sb, 30) !== c_exp) c_err++;
            end
        end
        check("preamble_errors", pre_err, 0);
        check("biphase_errors", bp_err, 0);
        check("parity_errors", par_err, 0);
        check("v_bit_errors", v_err, 0);
        check("u_bit_errors", u_err, 0);
        check("c_bit_errors", c_err, 0);

        // Stop at phase 40 of frame 195: frame completes, then the line holds
        idx_end  = fbase(195) + 127;
        hold_err = 0;
        for (int i = 1; i <= 100; i++) begin
            if (hist[idx_end + i] !== hist[idx_end]) hold_err++;
        end
        check("stop_hold_changes", hold_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
